// File: rtl/accumulator_sequencer.sv
// Accumulator sequencer: turns button levels into edge commands and drives a
// shared 8-bit adder over two cycles to add register 1 into 16-bit register 2.
module accumulator_sequencer #(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int HOLDOFF = 4
) (
    input  logic              MCLK,
    input  logic              rst_n,
    input  logic              btn_load,
    input  logic              btn_add,
    input  logic [DATA_W-1:0] sw,
    input  logic [DATA_W-1:0] reg1_q,
    input  logic [DATA_W-1:0] reg2_lsb_q,
    input  logic [DATA_W-1:0] reg2_msb_q,
    output logic [DATA_W-1:0] adder_a,
    output logic [DATA_W-1:0] adder_b,
    output logic              adder_cin,
    input  logic [DATA_W-1:0] adder_sum,
    input  logic              adder_cout,
    output logic [DATA_W-1:0] wr_data,
    output logic              reg1_we,
    output logic              reg2_lsb_we,
    output logic              reg2_msb_we,
    output logic              busy,
    output logic [CNT_W-1:0]  add_count,
    output logic              overflow
);

    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ADD_LSB,
        S_ADD_MSB
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                prev_load;
    logic                prev_add;
    logic                carry;
    logic [HOLD_W-1:0]   hold;
    logic                load_edge;
    logic                add_edge;
    logic                accept;

    assign load_edge = btn_load & ~prev_load;
    assign add_edge  = btn_add & ~prev_add;
    assign accept    = (hold == '0);

    // State register
    always_ff @(posedge MCLK) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Button history, carry, holdoff timer, add counter and sticky overflow
    always_ff @(posedge MCLK) begin
        if (!rst_n) begin
            prev_load <= 1'b1;
            prev_add  <= 1'b1;
            carry     <= 1'b0;
            hold      <= '0;
            add_count <= '0;
            overflow  <= 1'b0;
        end else begin
            prev_load <= btn_load;
            prev_add  <= btn_add;
            unique case (state)
                S_IDLE: begin
                    if (hold != '0) begin
                        hold <= hold - HOLD_W'(1);
                    end
                end
                S_LOAD: begin
                    hold <= HOLD_W'(HOLDOFF);
                end
                S_ADD_LSB: begin
                    carry <= adder_cout;
                end
                S_ADD_MSB: begin
                    hold      <= HOLD_W'(HOLDOFF);
                    add_count <= add_count + CNT_W'(1);
                    overflow  <= overflow | adder_cout;
                end
                default: begin
                    hold <= '0;
                end
            endcase
        end
    end

    // Next-state decode and datapath steering
    always_comb begin
        state_next  = state;
        adder_a     = '0;
        adder_b     = '0;
        adder_cin   = 1'b0;
        wr_data     = '0;
        reg1_we     = 1'b0;
        reg2_lsb_we = 1'b0;
        reg2_msb_we = 1'b0;
        busy        = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (accept && load_edge) begin
                    state_next = S_LOAD;
                end else if (accept && add_edge) begin
                    state_next = S_ADD_LSB;
                end
            end
            S_LOAD: begin
                reg1_we    = 1'b1;
                wr_data    = sw;
                state_next = S_IDLE;
            end
            S_ADD_LSB: begin
                adder_a     = reg2_lsb_q;
                adder_b     = reg1_q;
                adder_cin   = 1'b0;
                reg2_lsb_we = 1'b1;
                wr_data     = adder_sum;
                state_next  = S_ADD_MSB;
            end
            S_ADD_MSB: begin
                adder_a     = reg2_msb_q;
                adder_b     = '0;
                adder_cin   = carry;
                reg2_msb_we = 1'b1;
                wr_data     = adder_sum;
                state_next  = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/accumulator_sequencer.md
Name: accumulator_sequencer

Overview:
Control block for the board-level adder/accumulator. It turns front-panel button levels into edge-qualified commands and sequences a shared external 8-bit adder over two cycles to accumulate register 1 into the 16-bit register 2 (LSB pass, then MSB pass with carry). It drives the write enables for all datapath registers and keeps a completed-add counter and a sticky overflow flag. It sits between the button/switch inputs and the register file / adder inside the top-level adder-accumulator.

Parameters:
DATA_W, 8, datapath byte width (sw, register halves, adder width)
CNT_W, 16, width of add_count
HOLDOFF, 4, cycles after returning to IDLE during which new button edges are ignored (0 = no lockout)

Ports:
MCLK  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
btn_load  input  1  load button level, already synchronised to MCLK
btn_add  input  1  add button level, already synchronised to MCLK
sw  input  DATA_W  switch value to load into register 1
reg1_q  input  DATA_W  current register 1 value
reg2_lsb_q  input  DATA_W  current register 2 low byte
reg2_msb_q  input  DATA_W  current register 2 high byte
adder_a  output  DATA_W  adder operand A
adder_b  output  DATA_W  adder operand B
adder_cin  output  1  adder carry in
adder_sum  input  DATA_W  combinational adder sum (same cycle)
adder_cout  input  1  combinational adder carry out
wr_data  output  DATA_W  write data for whichever enable is active
reg1_we  output  1  register 1 write enable
reg2_lsb_we  output  1  register 2 LSB write enable
reg2_msb_we  output  1  register 2 MSB write enable
busy  output  1  high while not IDLE
add_count  output  CNT_W  number of completed adds, wraps
overflow  output  1  sticky: an add carried out of bit 15

Behaviour:
- Clock MCLK; reset synchronous, active-low (rst_n); single clock domain.
- Reset: state IDLE, every output 0, add_count 0, overflow 0, internal carry 0, holdoff counter 0. Both button-history registers reset to 1, so a button held through reset release does not fire; it must be released and re-pressed.
- Edge detect: edge = level & ~prev, prev registered every cycle in every state.
- IDLE: all enables 0, adder_a/adder_b/adder_cin/wr_data 0. An edge is accepted only if holdoff counter == 0. Load edge -> LOAD; else add edge -> ADD_LSB. Simultaneous load and add edges: load wins, add is dropped.
- LOAD (1 cycle): reg1_we=1, wr_data=sw -> IDLE.
- ADD_LSB (1 cycle): adder_a=reg2_lsb_q, adder_b=reg1_q, adder_cin=0; reg2_lsb_we=1, wr_data=adder_sum; carry register <= adder_cout -> ADD_MSB.
- ADD_MSB (1 cycle): adder_a=reg2_msb_q, adder_b=0, adder_cin=carry register; reg2_msb_we=1, wr_data=adder_sum; add_count += 1 (mod 2^CNT_W); overflow <= overflow | adder_cout -> IDLE.
- Timing: edge sampled on cycle N -> LOAD on N+1, or ADD_LSB on N+1 and ADD_MSB on N+2. busy is high exactly in those state cycles. Add latency is 2 cycles from accept to final write.
- Holdoff: on every transition into IDLE from LOAD/ADD_MSB, holdoff counter <= HOLDOFF. It decrements each IDLE cycle to 0. Edges seen while counter != 0 or while busy are discarded, not queued.
- At most one write enable is high in any cycle.
- Reset mid-operation (rst_n low during ADD_LSB/ADD_MSB): next state IDLE, no further enables. An LSB already written is not undone. add_count and overflow are cleared.
- overflow clears only on reset.

Test Plan:
1. Hold btn_add=1 across rst_n release for 10 cycles -> no write enables, add_count=0. Release, then re-press -> exactly one ADD_LSB/ADD_MSB pair.
2. sw=8'd2, pulse btn_load -> reg1_we high exactly 1 cycle with wr_data=2, busy for 1 cycle, add_count unchanged.
3. reg1_q=2, reg2={0x00,0xFF}, press add -> ADD_LSB: wr_data=0x01, carry=1. ADD_MSB: adder_cin=1, wr_data=0x01 (total 0x0101). busy 2 cycles, add_count=1, overflow=0.
4. With a register model and reg1=2, run 300 adds separated by the holdoff interval -> total 600 (0x0258), add_count=300.
5. reg2=0xFFFF, reg1=1, add -> total 0x0000, overflow=1. A further add of 1 -> 0x0001, overflow remains 1.
6. Apply load and add edges in the same cycle -> only reg1_we pulses. An add edge during busy, or within HOLDOFF=4 idle cycles, is ignored. An add edge on the 5th idle cycle is accepted.
